// File: rtl/bram_stream_reader_m.sv
`default_nettype none
// ============================================================================
// Module   : bram_stream_reader_m
// Purpose  : Initiator-side read engine for the BRAM stream slave. Takes a
//            read job (base address, total beats), splits it into slave
//            instructions of at most MAX_LEN beats ({addr[25:13],len[12:0]}),
//            checks the returned burst framing and forwards the 128-bit data
//            through a 2-entry registered skid buffer, tagging the final beat
//            of the job with tlast.
// Options  : `define BRAM_READER_PERF_EN to build the job cycle counter on
//            perf_cycles; otherwise perf_cycles is tied to zero.
// Ports    : clk, rst_n (synchronous, active-low)
//            s_job_*       job input  {rsvd[31:29], beats[28:13], addr[12:0]}
//            m_instruct_*  instruction output to the slave (one outstanding)
//            s_in_*        read data returned by the slave
//            m_data_*      forwarded data stream (tkeep all ones)
//            done          one-cycle pulse when a job has fully drained
//            err           sticky burst-framing error, cleared on job accept
//            perf_cycles   cycles spent outside IDLE for the current job
// Revision : 1.0 - initial release
// ============================================================================
module bram_stream_reader_m #(
    parameter int MAX_LEN = 256     // beats per instruction, 1..8191
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  s_job_tdata,
    input  logic         s_job_tvalid,
    output logic         s_job_tready,
    output logic [63:0]  m_instruct_tdata,
    output logic         m_instruct_tvalid,
    input  logic         m_instruct_tready,
    input  logic [127:0] s_in_tdata,
    input  logic         s_in_tvalid,
    output logic         s_in_tready,
    input  logic         s_in_tlast,
    output logic [127:0] m_data_tdata,
    output logic         m_data_tvalid,
    input  logic         m_data_tready,
    output logic [15:0]  m_data_tkeep,
    output logic         m_data_tlast,
    output logic         done,
    output logic         err,
    output logic [31:0]  perf_cycles
);

    localparam logic [15:0] c_max_len = 16'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DATA  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [12:0] addr_q, addr_d;            // address of the next instruction
    logic [15:0] remaining_q, remaining_d;  // beats of the job still to receive
    logic [12:0] burst_cnt_q, burst_cnt_d;  // beats of the current burst to receive
    logic [12:0] len_q, len_d;              // length of the current burst
    logic        err_q, err_d;
    logic        done_q, done_d;

    // ------------------------------------------------------------------
    // Skid buffer storage
    // ------------------------------------------------------------------
    logic [127:0] buf_data_q [2];
    logic         buf_last_q [2];
    logic         wr_ptr_q, rd_ptr_q;
    logic [1:0]   count_q, count_d;

    // ------------------------------------------------------------------
    // Handshakes and derived values
    // ------------------------------------------------------------------
    logic        w_job_fire;
    logic        w_instr_fire;
    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_full;
    logic        w_empty;
    logic        w_burst_end;
    logic        w_job_end;
    logic [12:0] w_instr_len;
    logic [15:0] w_job_beats;
    logic        w_unused_bits;

    assign w_unused_bits = &{1'b0, s_job_tdata[31:29]};

    assign w_job_beats = s_job_tdata[28:13];
    assign w_full      = (count_q == 2'd2);
    assign w_empty     = (count_q == 2'd0);
    assign w_burst_end = (burst_cnt_q == 13'd1);
    assign w_job_end   = (remaining_q == 16'd1);

    // The slice is safe: below c_max_len the remaining count fits 13 bits.
    assign w_instr_len = (remaining_q < c_max_len) ? remaining_q[12:0] : c_max_len[12:0];

    assign w_job_fire   = s_job_tvalid & s_job_tready;
    assign w_instr_fire = m_instruct_tvalid & m_instruct_tready;
    assign w_in_fire    = s_in_tvalid & s_in_tready;
    assign w_out_fire   = m_data_tvalid & m_data_tready;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // done_q is high during the first IDLE cycle; a job is held off for that
    // cycle so acceptance always lands strictly after the done pulse.
    assign s_job_tready      = (state_q == S_IDLE) & ~done_q;

    // Instruction is a pure function of registers that only change on the
    // handshake, so it is naturally stable while waiting for tready.
    assign m_instruct_tvalid = (state_q == S_ISSUE);
    assign m_instruct_tdata  = (state_q == S_ISSUE) ? {38'd0, addr_q, w_instr_len} : 64'd0;

    assign s_in_tready       = (state_q == S_DATA) & ~w_full;

    assign m_data_tvalid     = ~w_empty;
    assign m_data_tdata      = buf_data_q[rd_ptr_q];
    assign m_data_tlast      = ~w_empty & buf_last_q[rd_ptr_q];
    assign m_data_tkeep      = 16'hffff;

    assign done              = done_q;
    assign err               = err_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        burst_cnt_d = burst_cnt_q;
        len_d       = len_q;
        err_d       = err_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_job_fire) begin
                    addr_d      = s_job_tdata[12:0];
                    remaining_d = w_job_beats;
                    err_d       = 1'b0;
                    state_d     = (w_job_beats == 16'd0) ? S_DONE : S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (w_instr_fire) begin
                    burst_cnt_d = w_instr_len;
                    len_d       = w_instr_len;
                    state_d     = S_DATA;
                end
            end

            S_DATA: begin
                if (w_in_fire) begin
                    burst_cnt_d = burst_cnt_q - 13'd1;
                    remaining_d = remaining_q - 16'd1;
                    // Framing is only reported; burst progress follows our
                    // own count regardless of what the slave's tlast says.
                    if (s_in_tlast != w_burst_end) begin
                        err_d = 1'b1;
                    end
                    if (w_burst_end) begin
                        addr_d  = addr_q + len_q;   // 13-bit wrap is intended
                        state_d = w_job_end ? S_DONE : S_ISSUE;
                    end
                end
            end

            S_DONE: begin
                if (w_empty) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Occupancy: push and pop may coincide and then cancel out.
    always_comb begin
        count_d = count_q + {1'b0, w_in_fire} - {1'b0, w_out_fire};
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= 13'd0;
            remaining_q <= 16'd0;
            burst_cnt_q <= 13'd0;
            len_q       <= 13'd0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            burst_cnt_q <= burst_cnt_d;
            len_q       <= len_d;
            err_q       <= err_d;
            done_q      <= done_d;
            count_q     <= count_d;
            if (w_in_fire) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (w_out_fire) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Data slots carry no reset; they are qualified by the occupancy count.
    // The tlast tag marks the beat that brings the job's remaining count to 0.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            buf_data_q[wr_ptr_q] <= s_in_tdata;
            buf_last_q[wr_ptr_q] <= w_job_end;
        end
    end

    // ------------------------------------------------------------------
    // Optional job cycle counter
    // ------------------------------------------------------------------
`ifdef BRAM_READER_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= 32'd0;
        end else if (w_job_fire) begin
            perf_q <= 32'd0;
        end else if ((state_q != S_IDLE) && (perf_q != 32'hffff_ffff)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule
`default_nettype wire
